// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port between the WB stage (always wins)
// and a small FIFO of auxiliary writes drained into idle WB slots.
module rf_write_scheduler #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wb_we,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 aux_valid,
  input  logic [ADDR_W-1:0]    aux_addr,
  input  logic [DATA_W-1:0]    aux_data,
  output logic                 aux_ready,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_addr,
  output logic [DATA_W-1:0]    rf_data,
  output logic [2**ADDR_W-1:0] pending_mask,
  output logic                 stall_req
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  q_vld;
  logic [DEPTH-1:0]  q_vld_nxt;
  logic [DEPTH-1:0]  squash;
  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [WAIT_W-1:0] wait_cnt;

  logic q_nonempty;
  logic head_vld;
  logic any_vld;
  logic push;
  logic pop;
  logic valid_pop;
  logic blocked;

  always_comb begin
    q_nonempty = (count != '0);
    head_vld   = q_nonempty && q_vld[rd_ptr];
    any_vld    = |q_vld;
    aux_ready  = (count < CNT_W'(DEPTH)) && !flush;
    push       = aux_valid && aux_ready;
    // Invalid (squashed) heads retire even under a WB write; valid heads wait for a free slot.
    pop        = !flush && q_nonempty && (!wb_we || !q_vld[rd_ptr]);
    valid_pop  = pop && q_vld[rd_ptr];
    blocked    = head_vld && wb_we;
  end

  // A WB write supersedes any older queued write to the same register.
  always_comb begin
    squash = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_we && q_vld[i] && (q_addr[i] == wb_addr)) squash[i] = 1'b1;
    end
  end

  always_comb begin
    q_vld_nxt = q_vld & ~squash;
    if (pop)  q_vld_nxt[rd_ptr] = 1'b0;
    if (push) q_vld_nxt[wr_ptr] = 1'b1;
    if (flush) q_vld_nxt = '0;
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i]) pending_mask[q_addr[i]] = 1'b1;
    end
  end

  // Queue control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      q_vld  <= '0;
    end else begin
      q_vld <= q_vld_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end
  end

  // Queue payload carries no reset; its valid bits guard it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= aux_addr;
      q_data[wr_ptr] <= aux_data;
    end
  end

  // Write port stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else if (wb_we) begin
      rf_we   <= 1'b1;
      rf_addr <= wb_addr;
      rf_data <= wb_data;
    end else if (valid_pop) begin
      rf_we   <= 1'b1;
      rf_addr <= q_addr[rd_ptr];
      rf_data <= q_data[rd_ptr];
    end else begin
      rf_we   <= 1'b0;
    end
  end

  // Starvation tracking: stall fires on the MAX_WAIT-th consecutive blocked cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt  <= '0;
      stall_req <= 1'b0;
    end else if (flush || valid_pop) begin
      wait_cnt  <= '0;
      stall_req <= 1'b0;
    end else if (!any_vld) begin
      wait_cnt  <= '0;
    end else if (blocked) begin
      if (wait_cnt >= WAIT_W'(MAX_WAIT - 1)) stall_req <= 1'b1;
      if (wait_cnt != WAIT_W'(MAX_WAIT))     wait_cnt  <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed scenarios then random traffic, all checked
// against a queue-based reference model of the write-port rules.
module tb_rf_write_scheduler;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NREG     = 2**ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wb_we = 1'b0;
  logic [ADDR_W-1:0] wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              aux_valid = 1'b0;
  logic [ADDR_W-1:0] aux_addr = '0;
  logic [DATA_W-1:0] aux_data = '0;
  logic              aux_ready;
  logic              flush = 1'b0;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic [NREG-1:0]   pending_mask;
  logic              stall_req;

  rf_write_scheduler #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_data(aux_data), .aux_ready(aux_ready),
    .flush(flush),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .pending_mask(pending_mask), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  string phase = "init";

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                v;
  } ent_t;

  // Reference state: queue index 0 is the oldest entry.
  ent_t              q[$];
  bit                m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                m_stall;
  int                m_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] m_mask();
    logic [NREG-1:0] m = '0;
    foreach (q[i]) if (q[i].v) m[q[i].a] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we = 0; m_addr = '0; m_data = '0; m_stall = 0; m_wait = 0;
  endtask

  task automatic model_step(input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                            input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                            input bit fl);
    bit headv, anyv, do_push, popping, vpop;
    if (fl) begin
      m_we = we;
      if (we) begin m_addr = wa; m_data = wd; end
      q.delete();
      m_wait = 0; m_stall = 0;
      return;
    end
    headv = (q.size() > 0) && q[0].v;
    anyv = 0;
    foreach (q[i]) if (q[i].v) anyv = 1;
    do_push = av && (q.size() < DEPTH);
    popping = (q.size() > 0) && (!we || !q[0].v);
    vpop    = popping && q[0].v;
    if (we) begin
      m_we = 1; m_addr = wa; m_data = wd;
    end else if (vpop) begin
      m_we = 1; m_addr = q[0].a; m_data = q[0].d;
    end else begin
      m_we = 0;
    end
    if (vpop) begin
      m_wait = 0; m_stall = 0;
    end else if (!anyv) begin
      m_wait = 0;
    end else if (headv && we) begin
      if (m_wait >= MAX_WAIT - 1) m_stall = 1;
      if (m_wait < MAX_WAIT) m_wait++;
    end
    if (popping) void'(q.pop_front());
    if (we) foreach (q[i]) if (q[i].v && q[i].a == wa) q[i].v = 0;
    if (do_push) q.push_back('{a: aa, d: ad, v: 1'b1});
  endtask

  // Entered and left at posedge+1; drives one cycle of inputs and checks both sides of the edge.
  task automatic cycle(input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input bit fl);
    wb_we = we; wb_addr = wa; wb_data = wd;
    aux_valid = av; aux_addr = aa; aux_data = ad;
    flush = fl;
    #1;
    chk("aux_ready", 64'(aux_ready), 64'((q.size() < DEPTH) && !fl));
    chk("pending_mask", 64'(pending_mask), 64'(m_mask()));
    model_step(we, wa, wd, av, aa, ad, fl);
    @(posedge clk);
    #1;
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_addr", 64'(rf_addr), 64'(m_addr));
    chk("rf_data", 64'(rf_data), 64'(m_data));
    chk("stall_req", 64'(stall_req), 64'(m_stall));
  endtask

  task automatic idle();
    cycle(0, '0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    wb_we = 0; aux_valid = 0; flush = 0;
    #1;
    model_reset();
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_rf_addr", 64'(rf_addr), 64'(0));
    chk("rst_rf_data", 64'(rf_data), 64'(0));
    chk("rst_stall", 64'(stall_req), 64'(0));
    chk("rst_pending", 64'(pending_mask), 64'(0));
    chk("rst_aux_ready", 64'(aux_ready), 64'(1));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int seen_a, seen_c, aux_writes;

    phase = "reset";
    do_reset();
    idle();
    idle();

    phase = "wb_only";
    cycle(1, 4'd3, 32'hDEADBEEF, 0, '0, '0, 0);
    chk("wb_we", 64'(rf_we), 64'(1));
    chk("wb_addr", 64'(rf_addr), 64'(3));
    chk("wb_data", 64'(rf_data), 64'hDEADBEEF);
    idle();

    phase = "aux_free_slot";
    cycle(0, '0, '0, 1, 4'd5, 32'h11, 0);
    chk("mask_r5", 64'(pending_mask), 64'h0020);
    idle();
    chk("aux_we", 64'(rf_we), 64'(1));
    chk("aux_addr", 64'(rf_addr), 64'(5));
    chk("aux_data", 64'(rf_data), 64'h11);
    idle();
    chk("mask_clear", 64'(pending_mask), 64'(0));

    phase = "fill_starve";
    for (int i = 1; i <= 4; i++) cycle(1, 4'd9, $urandom, 1, 4'(i), 32'(i), 0);
    chk("full_not_ready", 64'(aux_ready), 64'(0));
    n = 0;
    while (!stall_req && n < 20) begin
      cycle(1, 4'd9, $urandom, 0, '0, '0, 0);
      n++;
    end
    // Three blocked cycles elapsed during the fill, so five more reach the eighth.
    chk("stall_rise_cycles", 64'(n), 64'(5));
    cycle(0, '0, '0, 0, '0, '0, 0);
    chk("r1_we", 64'(rf_we), 64'(1));
    chk("r1_addr", 64'(rf_addr), 64'(1));
    chk("r1_data", 64'(rf_data), 64'(1));
    chk("stall_fall", 64'(stall_req), 64'(0));
    for (int i = 0; i < 4; i++) idle();

    phase = "squash";
    cycle(0, '0, '0, 1, 4'd7, 32'hA, 0);
    cycle(1, 4'd7, 32'hB, 1, 4'd7, 32'hC, 0);
    chk("wb_r7", 64'(rf_data), 64'hB);
    seen_a = 0; seen_c = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (rf_we && rf_addr == 4'd7 && rf_data == 32'hA) seen_a++;
      if (rf_we && rf_addr == 4'd7 && rf_data == 32'hC) seen_c++;
    end
    chk("squashed_writes", 64'(seen_a), 64'(0));
    chk("newer_writes", 64'(seen_c), 64'(1));

    phase = "flush";
    for (int i = 0; i < 3; i++) cycle(1, 4'd11, 32'h77, 1, 4'(8 + i), 32'(100 + i), 0);
    cycle(1, 4'd2, 32'h5, 1, 4'd12, 32'h99, 1);
    chk("flush_wb_we", 64'(rf_we), 64'(1));
    chk("flush_wb_addr", 64'(rf_addr), 64'(2));
    chk("flush_wb_data", 64'(rf_data), 64'h5);
    chk("flush_mask", 64'(pending_mask), 64'(0));
    aux_writes = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      if (rf_we) aux_writes++;
    end
    chk("flush_no_aux", 64'(aux_writes), 64'(0));

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        phase = "mid_reset";
        do_reset();
        phase = "random";
      end
      cycle(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom,
            bit'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
